// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit holding the HI/LO
// registers. It implements MULT, MULTU, DIV and DIVU (one bit per cycle:
// shift-add for multiply, restoring division for divide) and MTHI/MTLO.
// Signed operations run on operand magnitudes; the sign is fixed up on exit.
//
// Optional feature macro: MULT_FAST_EN
//   defined   -> MULT/MULTU use a single-cycle multiplier (IDLE -> DONE)
//   undefined -> every operation iterates through CALC
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ITER_CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  mthi_i,
  input  logic                  mtlo_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_by_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  localparam int W = DATA_WIDTH;

  // op_i[1] selects divide, op_i[0] selects unsigned
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Magnitude of a two's-complement value; the most negative value maps to
  // its own bit pattern, which is the correct unsigned magnitude.
  function automatic logic [W-1:0] abs_val(input logic signed [W-1:0] v);
    logic signed [W-1:0] n;
    n = -v;
    return v[W-1] ? $unsigned(n) : $unsigned(v);
  endfunction

  // Conditional two's-complement negation, single width
  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
    logic signed [W-1:0] s;
    s = -$signed(v);
    return n ? $unsigned(s) : v;
  endfunction

  // Conditional two's-complement negation, double width (product)
  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic n);
    logic signed [2*W-1:0] s;
    s = -$signed(v);
    return n ? $unsigned(s) : v;
  endfunction

  state_t                state_q,   state_d;
  logic [1:0]            op_q,      op_d;
  logic [W-1:0]          mcand_q,   mcand_d;    // multiplicand or divisor magnitude
  logic [2*W-1:0]        acc_q,     acc_d;      // {upper, lower} working register
  logic [ITER_CNT_W-1:0] cnt_q,     cnt_d;
  logic                  sign_q,    sign_d;     // product / quotient negative
  logic                  rsign_q,   rsign_d;    // remainder negative
  logic                  dbz_q,     dbz_d;      // pending divide-by-zero completion
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  dbzo_q,    dbzo_d;
  logic [W-1:0]          hi_q,      hi_d;
  logic [W-1:0]          lo_q,      lo_d;

  logic                  a_neg, b_neg;
  logic [W-1:0]          a_mag, b_mag;
  logic [W:0]            mul_sum;
  logic [2*W-1:0]        mul_next;
  logic [W:0]            div_rem;
  logic [W:0]            div_diff;
  logic [2*W-1:0]        div_next;
  logic [2*W-1:0]        fix_prod;

`ifdef MULT_FAST_EN
  logic [2*W-1:0]        fast_prod;
  assign fast_prod = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
`endif

  // Operand sign detection and magnitude extraction for signed operations
  always_comb begin
    a_neg = ~op_i[0] & a_i[W-1];
    b_neg = ~op_i[0] & b_i[W-1];
    a_mag = a_neg ? abs_val($signed(a_i)) : a_i;
    b_mag = b_neg ? abs_val($signed(b_i)) : b_i;
  end

  // One multiply step and one restoring-divide step from the current accumulator
  always_comb begin
    // Multiply: lower half holds the remaining multiplier bits, LSB first
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
    // Divide: shift the next dividend bit into the partial remainder, which
    // may momentarily need W+1 bits before the trial subtraction
    div_rem  = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff = div_rem - {1'b0, mcand_q};
    div_next = div_diff[W] ? {div_rem[W-1:0],  acc_q[W-2:0], 1'b0}
                           : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    fix_prod = neg_2w(acc_q, sign_q);
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    rsign_d = rsign_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbzo_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          mcand_d = b_mag;
          acc_d   = {{W{1'b0}}, a_mag};
          cnt_d   = '0;
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          if (op_i[1]) begin
            sign_d  = a_neg ^ b_neg;
            rsign_d = a_neg;
          end else begin
            sign_d  = a_neg ^ b_neg;
            rsign_d = 1'b0;
          end
          if (op_i[1] && (b_i == '0)) begin
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
`ifdef MULT_FAST_EN
            if (!op_i[1]) begin
              acc_d   = fast_prod;
              state_d = ST_DONE;
            end else begin
              state_d = ST_CALC;
            end
`else
            state_d = ST_CALC;
`endif
          end
        end else begin
          if (mthi_i) hi_d = a_i;
          if (mtlo_i) lo_d = a_i;
        end
      end

      ST_CALC: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ITER_CNT_W'(W - 1)) state_d = ST_DONE;
      end

      ST_DONE: begin
        if (!dbz_q) begin
          unique case (op_q)
            OP_DIV, OP_DIVU: begin
              lo_d = neg_w(acc_q[W-1:0],   sign_q);
              hi_d = neg_w(acc_q[2*W-1:W], rsign_q);
            end
            OP_MULT, OP_MULTU: begin
              hi_d = fix_prod[2*W-1:W];
              lo_d = fix_prod[W-1:0];
            end
            default: ;
          endcase
        end
        dbzo_d  = dbz_q;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation and clears HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      rsign_q <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbzo_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      rsign_q <= rsign_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbzo_q  <= dbzo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbzo_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed and random operations checked
// against an arithmetic reference of the HI/LO architectural state.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        mthi_i, mtlo_i;
  logic        busy_o, done_o, div_by_zero_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  // Reference architectural HI/LO
  logic [31:0] m_hi, m_lo;

  mult_div_unit #(.DATA_WIDTH(32), .ITER_CNT_W(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .op_i          (op_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .mthi_i        (mthi_i),
    .mtlo_i        (mtlo_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .div_by_zero_o (div_by_zero_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Edges from the start edge until done_o is seen
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    if (op[1] && b == 32'd0) return 1;
`ifdef MULT_FAST_EN
    if (!op[1]) return 1;
`endif
    return 33;
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit inject, input bit with_move, input string tag);
    logic [31:0] e_hi, e_lo, h0, l0;
    logic        e_dbz;
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    int          edges;
    bit          busy_ok, stable_ok;
    e_hi  = m_hi;
    e_lo  = m_lo;
    e_dbz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; e_hi = p[63:32]; e_lo = p[31:0]; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; e_hi = up[63:32]; e_lo = up[31:0]; end
      2'b10: begin
        if (b == 32'd0) e_dbz = 1'b1;
        else begin q = sa / sb; r = sa % sb; e_lo = q[31:0]; e_hi = r[31:0]; end
      end
      default: begin
        if (b == 32'd0) e_dbz = 1'b1;
        else begin e_lo = a / b; e_hi = a % b; end
      end
    endcase

    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    mthi_i = with_move; mtlo_i = with_move;
    h0 = hi_o; l0 = lo_o;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
    op_i = 2'($urandom_range(0, 3)); a_i = $urandom; b_i = $urandom;
    edges = 0; busy_ok = 1'b1; stable_ok = 1'b1;
    while (done_o !== 1'b1 && edges < 60) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (hi_o !== h0 || lo_o !== l0) stable_ok = 1'b0;
      if (inject && edges == 9)  begin start_i = 1'b1; op_i = 2'b01; mthi_i = 1'b1; a_i = 32'hDEAD; end
      if (inject && edges == 10) begin start_i = 1'b0; mthi_i = 1'b0; end
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    start_i = 1'b0; mthi_i = 1'b0;
    chk({tag, "_latency"}, 64'(edges), 64'(exp_lat(op, b)));
    chk({tag, "_busy_held"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, "_hilo_stable"}, {63'd0, stable_ok}, 64'd1);
    chk({tag, "_busy_at_done"}, {63'd0, busy_o}, 64'd0);
    chk({tag, "_hi"}, {32'd0, hi_o}, {32'd0, e_hi});
    chk({tag, "_lo"}, {32'd0, lo_o}, {32'd0, e_lo});
    chk({tag, "_dbz"}, {63'd0, div_by_zero_o}, {63'd0, e_dbz});
    m_hi = e_hi;
    m_lo = e_lo;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {62'd0, done_o, div_by_zero_o}, 64'd0);
  endtask

  task automatic do_move(input bit hw, input bit lw, input logic [31:0] d, input string tag);
    @(negedge clk);
    mthi_i = hw; mtlo_i = lw; a_i = d;
    @(posedge clk);
    @(negedge clk);
    mthi_i = 1'b0; mtlo_i = 1'b0;
    if (hw) m_hi = d;
    if (lw) m_lo = d;
    chk({tag, "_hi"}, {32'd0, hi_o}, {32'd0, m_hi});
    chk({tag, "_lo"}, {32'd0, lo_o}, {32'd0, m_lo});
    chk({tag, "_no_done"}, {62'd0, done_o, busy_o}, 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    mthi_i = 1'b0; mtlo_i = 1'b0;
    m_hi = '0; m_lo = '0;
    #2 reset = 1'b0;
    #1;
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_flags", {62'd0, done_o, div_by_zero_o}, 64'd0);
    chk("reset_hilo", {hi_o, lo_o}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, "multu_max");
    chk("multu_max_const", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);
    do_op(2'b00, 32'hFFFFFFFD, 32'd5, 0, 0, "mult_neg");
    chk("mult_neg_const", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF1);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, 0, "div_neg");
    chk("div_neg_const", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(2'b11, 32'd100, 32'd7, 0, 0, "divu");
    chk("divu_const", {hi_o, lo_o}, {32'd2, 32'd14});

    do_move(1, 0, 32'h11111111, "mthi");
    do_move(0, 1, 32'h22222222, "mtlo");
    do_op(2'b11, 32'd100, 32'd0, 0, 0, "divu_zero");
    chk("divu_zero_const", {hi_o, lo_o}, 64'h11111111_22222222);
    do_op(2'b10, 32'h12345678, 32'd0, 0, 0, "div_zero");
    do_move(1, 1, 32'h33333333, "mt_both");

    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, 0, "div_ovf_inject");
    chk("div_ovf_const", {hi_o, lo_o}, 64'h00000000_80000000);
    do_op(2'b00, 32'hFFFFFFFD, 32'd7, 0, 1, "start_beats_move");
    do_op(2'b10, 32'd7, 32'hFFFFFFFE, 0, 0, "div_pos_neg");

    // Reset in the middle of an iterative multiply
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd3; b_i = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset_busy", {63'd0, busy_o}, 64'd0);
    chk("midreset_hilo", {hi_o, lo_o}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    do_op(2'b01, 32'd3, 32'd4, 0, 0, "multu_after_reset");
    chk("multu_after_reset_const", {hi_o, lo_o}, 64'd12);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      do_op(rop, ra, rb, 0, 0, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit in the execute stage, beside the ALU. Consumes the same rs/rt operands.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. Holds the architectural HI/LO registers.
- hi_o/lo_o feed the execute-stage result mux for MFHI/MFLO.
- The hazard unit stalls the pipeline while busy_o is high.

Parameters:
- DATA_WIDTH, 32, operand width. HI and LO are each DATA_WIDTH wide; the product is 2*DATA_WIDTH.
- ITER_CNT_W, 6, iteration counter width. Must satisfy 2^ITER_CNT_W > DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start_i  input  1  start request; sampled only in IDLE
- op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
- a_i  input  DATA_WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
- b_i  input  DATA_WIDTH  rt operand (multiplier / divisor)
- mthi_i  input  1  write a_i to HI
- mtlo_i  input  1  write a_i to LO
- busy_o  output  1  operation in progress
- done_o  output  1  one-cycle pulse: HI/LO updated
- div_by_zero_o  output  1  one-cycle pulse coincident with done_o on divide by zero
- hi_o  output  DATA_WIDTH  HI register
- lo_o  output  DATA_WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy_o=0, done_o=0, div_by_zero_o=0, hi_o=0, lo_o=0; internal operand, accumulator and counter registers cleared.
- Reset asserted mid-operation aborts the operation. HI/LO read 0 immediately, not their pre-operation values.
- States:
  - IDLE: busy_o=0. If start_i=1 at edge E0: latch op_i, operand magnitudes (signed ops use the absolute value) and the result-sign flags.
    - Divide with b_i=0: go to DONE.
    - Otherwise: clear the counter and go to CALC.
  - CALC: busy_o=1. One iteration per edge, E1..E32.
    - Multiply: shift-add, one multiplier bit per cycle into a 2*DATA_WIDTH accumulator.
    - Divide: restoring, one quotient bit per cycle.
    - Go to DONE at the edge where counter reaches DATA_WIDTH.
  - DONE: busy_o=1. At the next edge (E33 normally; E1 for divide by zero):
    - apply sign fixup;
    - write HI/LO;
    - drive done_o=1 (and div_by_zero_o if applicable) for exactly one cycle;
    - return to IDLE.
  - busy_o is a registered output: high from E0 until the DONE exit edge.
- Results:
  - MULT/MULTU: {HI,LO} = 64-bit product, signed or unsigned.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed divide: quotient negative iff the operand signs differ; remainder takes the sign of the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0x00000000, no flag.
  - Divide by zero: HI/LO unchanged; done_o=1 and div_by_zero_o=1 in the same cycle.
- MTHI/MTLO:
  - Honoured only in IDLE with start_i=0. HI (or LO) is written with a_i at the edge; no done_o.
  - mthi_i and mtlo_i both high writes both registers.
- Simultaneous and illegal events:
  - start_i and mthi_i/mtlo_i together in IDLE: start wins; the move is dropped.
  - start_i, mthi_i and mtlo_i while busy are ignored. They do not queue and do not disturb the operation.
  - start_i held high across done returns to IDLE, then begins a new operation at the next edge. Inputs are re-sampled at that edge.
  - a_i, b_i and op_i may change after E0 without effect.
- hi_o/lo_o are stable throughout CALC. Both change only at the DONE exit edge, a move, or reset.

Optional Feature:
- Macro: MULT_FAST_EN.
- Defined:
  - MULT/MULTU compute the full product with a single-cycle multiplier. The operation goes IDLE→DONE at E0, and HI/LO are written with done_o at E1.
  - busy_o is high for one cycle only.
  - Divide behaviour is unchanged.
- Undefined: all operations use the iterative CALC path; multiply latency is the same as divide.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at E0 → busy_o high E0..E33; done_o pulse after E33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. With MULT_FAST_EN: same values, done_o after E1.
- DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=100, b=7 → LO=14, HI=2.
- DIVU a=100, b=0 with HI/LO preloaded to 0x11111111/0x22222222 by MTHI/MTLO → done_o=1 and div_by_zero_o=1 after E1; HI/LO unchanged.
- Start DIV 0x80000000/0xFFFFFFFF; at E10 pulse mthi_i with a_i=0xDEAD and start_i with MULTU → both ignored. Result LO=0x80000000, HI=0 at E33.
- Start MULTU 3×4; assert reset low mid-CALC (E15) → busy_o=0, hi_o=lo_o=0 immediately. After release, a new MULTU 3×4 gives LO=12, HI=0.
